// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and bitwise CRC helpers for the stream engine
package crc_pkg;

    localparam int CRC_MAX_W = 32;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        r = {<<{b}};
        return r;
    endfunction

    // Reverse the whole word, then slide the reflected low field back down.
    function automatic logic [CRC_MAX_W-1:0] reflect_w(input logic [CRC_MAX_W-1:0] v,
                                                        input int width);
        logic [CRC_MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (CRC_MAX_W - width);
    endfunction

    function automatic logic [CRC_MAX_W-1:0] crc_byte_step(input logic [CRC_MAX_W-1:0] crc,
                                                           input logic [7:0]           data,
                                                           input logic [CRC_MAX_W-1:0] poly,
                                                           input int                   width);
        logic [CRC_MAX_W-1:0] r, top, mask;
        logic [7:0]           d;
        logic                 fb;
        top  = 32'h1 << (width - 1);
        mask = (width >= CRC_MAX_W) ? '1 : ((top << 1) - 32'h1);
        r    = crc & mask;
        d    = data;
        for (int i = 0; i < 8; i++) begin
            fb = ((r & top) != '0) ^ d[7];
            r  = ((r << 1) ^ (fb ? poly : '0)) & mask;
            d  = d << 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_lane_chain.sv
// rtl/crc_lane_chain.sv - combinational cascade of per-byte CRC steps over the valid lanes
module crc_lane_chain
    import crc_pkg::*;
#(
    parameter int                   WIDTH      = 32,
    parameter logic [CRC_MAX_W-1:0] POLY       = 32'h04C11DB7,
    parameter bit                   REFIN      = 1'b0,
    parameter int                   DATA_BYTES = 4,
    parameter int                   BW         = $clog2(DATA_BYTES + 1)
) (
    input  logic [WIDTH-1:0]        crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [BW-1:0]           bytes,
    output logic [WIDTH-1:0]        crc_next
);

    logic [WIDTH-1:0] r;
    logic [7:0]       b;
    int               n;

    // Out-of-range counts fall back to a full beat; unused lanes are skipped, not zero-fed.
    always_comb begin
        n = int'(bytes);
        if (n == 0 || n > DATA_BYTES) n = DATA_BYTES;
        r = crc_in;
        b = '0;
        for (int l = 0; l < DATA_BYTES; l++) begin
            if (l < n) begin
                b = data[8*l +: 8];
                if (REFIN) b = reflect8(b);
                r = WIDTH'(crc_byte_step(CRC_MAX_W'(r), b, POLY, WIDTH));
            end
        end
        crc_next = r;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - framed Rocksoft-model CRC engine with held result handshake
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int                   WIDTH      = 32,
    parameter logic [CRC_MAX_W-1:0] POLY       = 32'h04C11DB7,
    parameter logic [CRC_MAX_W-1:0] INIT       = 32'hFFFFFFFF,
    parameter bit                   REFIN      = 1'b0,
    parameter bit                   REFOUT     = 1'b0,
    parameter logic [CRC_MAX_W-1:0] XOROUT     = 32'h00000000,
    parameter logic [CRC_MAX_W-1:0] RESIDUE    = 32'h00000000,
    parameter int                   DATA_BYTES = 4,
    parameter int                   BW         = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [BW-1:0]           in_bytes,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        crc_out,
    output logic                    crc_ok,
    output logic                    busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_next, crc_final, crc_out_q;
    logic             crc_ok_q, accept, consume;

    crc_lane_chain #(
        .WIDTH(WIDTH), .POLY(POLY), .REFIN(REFIN), .DATA_BYTES(DATA_BYTES), .BW(BW)
    ) u_chain (
        .crc_in(crc_q), .data(in_data), .bytes(in_bytes), .crc_next(crc_next)
    );

    assign in_ready  = reset && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign crc_out   = crc_out_q;
    assign crc_ok    = crc_ok_q;

    always_comb begin
        crc_final = crc_next;
        if (REFOUT) crc_final = WIDTH'(reflect_w(CRC_MAX_W'(crc_next), WIDTH));
        crc_final = crc_final ^ XOROUT[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_last ? DONE : ACCUM;
            ACCUM:   if (accept && in_last) state_d = DONE;
            DONE:    if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            crc_q     <= INIT[WIDTH-1:0];
            crc_out_q <= '0;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                crc_q <= crc_next;
                if (in_last) begin
                    crc_out_q <= crc_final;
                    crc_ok_q  <= (crc_final == RESIDUE[WIDTH-1:0]);
                end
            end
            if (consume) crc_q <= INIT[WIDTH-1:0];
        end
    end

    property beat_legal;
        @(posedge clk) disable iff (!reset)
        accept |-> (int'(in_bytes) >= 1 && int'(in_bytes) <= DATA_BYTES &&
                    (in_last || int'(in_bytes) == DATA_BYTES));
    endproperty
    a_beat_legal: assert property (beat_legal);

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - directed vector bench over three engine configurations
module tb_crc_stream_engine;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_v, a_rdy, a_last, a_ov, a_ordy, a_ok, a_busy;
    logic [31:0] a_data, a_crc;
    logic [2:0]  a_nb;
    logic        b_v, b_rdy, b_last, b_ov, b_ordy, b_ok, b_busy;
    logic [7:0]  b_data;
    logic [0:0]  b_nb;
    logic [31:0] b_crc;
    logic        c_v, c_rdy, c_last, c_ov, c_ordy, c_ok, c_busy;
    logic [15:0] c_data, c_crc;
    logic [1:0]  c_nb;

    crc_stream_engine u_a (
        .clk(clk), .reset(reset), .in_valid(a_v), .in_ready(a_rdy), .in_data(a_data),
        .in_bytes(a_nb), .in_last(a_last), .out_valid(a_ov), .out_ready(a_ordy),
        .crc_out(a_crc), .crc_ok(a_ok), .busy(a_busy)
    );

    // Residue here is compared after XOROUT, so it is the complement of 0xDEBB20E3.
    crc_stream_engine #(
        .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF), .RESIDUE(32'h2144DF1C), .DATA_BYTES(1)
    ) u_b (
        .clk(clk), .reset(reset), .in_valid(b_v), .in_ready(b_rdy), .in_data(b_data),
        .in_bytes(b_nb), .in_last(b_last), .out_valid(b_ov), .out_ready(b_ordy),
        .crc_out(b_crc), .crc_ok(b_ok), .busy(b_busy)
    );

    crc_stream_engine #(
        .WIDTH(16), .POLY(32'h1021), .INIT(32'hFFFF), .DATA_BYTES(2)
    ) u_c (
        .clk(clk), .reset(reset), .in_valid(c_v), .in_ready(c_rdy), .in_data(c_data),
        .in_bytes(c_nb), .in_last(c_last), .out_valid(c_ov), .out_ready(c_ordy),
        .crc_out(c_crc), .crc_ok(c_ok), .busy(c_busy)
    );

    typedef struct {
        int           sel;
        logic [127:0] data;
        int           len;
        bit           gaps;
        bit           use_model;
        logic [31:0]  crc;
        logic         ok;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lanes_of(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 1 : 2);
    endfunction

    function automatic logic [31:0] residue_of(input int sel);
        return (sel == 1) ? 32'h2144DF1C : 32'h0;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_rdy : ((sel == 1) ? b_rdy : c_rdy);
    endfunction

    function automatic logic ov(input int sel);
        return (sel == 0) ? a_ov : ((sel == 1) ? b_ov : c_ov);
    endfunction

    function automatic logic okf(input int sel);
        return (sel == 0) ? a_ok : ((sel == 1) ? b_ok : c_ok);
    endfunction

    function automatic logic [31:0] crcf(input int sel);
        return (sel == 0) ? a_crc : ((sel == 1) ? b_crc : 32'(c_crc));
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] d, input int n, input logic last);
        case (sel)
            0:       begin a_v = v; a_data = d;        a_nb = 3'(n); a_last = last; end
            1:       begin b_v = v; b_data = d[7:0];   b_nb = 1'(n); b_last = last; end
            default: begin c_v = v; c_data = d[15:0]; c_nb = 2'(n); c_last = last; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic r);
        case (sel)
            0:       a_ordy = r;
            1:       b_ordy = r;
            default: c_ordy = r;
        endcase
    endtask

    function automatic logic [127:0] pack(input string s, input logic [31:0] tail, input int tn);
        logic [127:0] p = '0;
        for (int i = 0; i < s.len(); i++) p[8*i +: 8] = s[i];
        for (int k = 0; k < tn; k++) p[8*(s.len()+k) +: 8] = 8'(tail >> (8*(tn-1-k)));
        return p;
    endfunction

    function automatic logic [31:0] model(input int sel, input logic [127:0] data, input int len);
        int          w;
        logic [31:0] poly, r, xo;
        logic [7:0]  b;
        bit          ri, ro;
        w = (sel == 2) ? 16 : 32;
        poly = (sel == 2) ? 32'h1021 : 32'h04C11DB7;
        r = (sel == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
        ri = (sel == 1);
        ro = (sel == 1);
        xo = (sel == 1) ? 32'hFFFFFFFF : 32'h0;
        for (int k = 0; k < len; k++) begin
            b = data[8*k +: 8];
            if (ri) b = reflect8(b);
            r = crc_byte_step(r, b, poly, w);
        end
        if (ro) r = reflect_w(r, w);
        return r ^ xo;
    endfunction

    task automatic add(input int sel, input string s, input logic [31:0] tail, input int tn,
                       input bit gaps, input bit use_model, input logic [31:0] crc, input logic ok);
        vec_t v;
        v.sel = sel; v.data = pack(s, tail, tn); v.len = s.len() + tn;
        v.gaps = gaps; v.use_model = use_model; v.crc = crc; v.ok = ok;
        vecs.push_back(v);
    endtask

    task automatic send_frame(input int sel, input logic [127:0] data, input int len, input bit gaps);
        int          idx, n, w, lanes;
        logic [31:0] d;
        lanes = lanes_of(sel);
        idx = 0;
        while (idx < len) begin
            n = (len - idx < lanes) ? (len - idx) : lanes;
            d = '0;
            for (int k = 0; k < n; k++) d[8*k +: 8] = data[8*(idx+k) +: 8];
            if (gaps) begin
                drive(sel, 1'b0, '0, lanes, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drive(sel, 1'b1, d, n, (idx + n == len));
            w = 0;
            while (!rdy(sel) && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) chk("accept_timeout", 32'(w), 32'd0);
            @(negedge clk);
            idx += n;
        end
        drive(sel, 1'b0, '0, lanes, 1'b0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [31:0] exp;
        logic        exp_ok;
        exp    = v.use_model ? model(v.sel, v.data, v.len) : v.crc;
        exp_ok = v.use_model ? (exp == residue_of(v.sel)) : v.ok;
        send_frame(v.sel, v.data, v.len, v.gaps);
        chk({name, "_valid"}, 32'(ov(v.sel)), 32'd1);
        chk({name, "_crc"}, crcf(v.sel), exp);
        chk({name, "_ok"}, 32'(okf(v.sel)), 32'(exp_ok));
        set_ordy(v.sel, 1'b1);
        @(negedge clk);
        set_ordy(v.sel, 1'b0);
        chk({name, "_consumed"}, 32'(ov(v.sel)), 32'd0);
        chk({name, "_ready"}, 32'(rdy(v.sel)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        drive(0, 1'b0, '0, 4, 1'b0);
        drive(1, 1'b0, '0, 1, 1'b0);
        drive(2, 1'b0, '0, 2, 1'b0);
        a_ordy = 1'b0; b_ordy = 1'b0; c_ordy = 1'b0;

        add(0, "123456789", 32'h0,        0, 1'b0, 1'b0, 32'h0376E6E7, 1'b0);
        add(0, "123456789", 32'h0376E6E7, 4, 1'b0, 1'b0, 32'h00000000, 1'b1);
        add(0, "123456789", 32'h0376E6E6, 4, 1'b0, 1'b1, 32'h0,        1'b0);
        add(0, "123456789", 32'h0377E6E7, 4, 1'b0, 1'b1, 32'h0,        1'b0);
        add(0, "123456789", 32'h0,        0, 1'b1, 1'b0, 32'h0376E6E7, 1'b0);
        add(0, "9",         32'h0,        0, 1'b0, 1'b1, 32'h0,        1'b0);
        add(0, "12",        32'h0,        0, 1'b0, 1'b1, 32'h0,        1'b0);
        add(0, "1234",      32'h0,        0, 1'b0, 1'b1, 32'h0,        1'b0);
        add(1, "123456789", 32'h0,        0, 1'b0, 1'b0, 32'hCBF43926, 1'b0);
        add(1, "123456789", 32'h2639F4CB, 4, 1'b0, 1'b0, 32'h2144DF1C, 1'b1);
        add(2, "123456789", 32'h0,        0, 1'b0, 1'b0, 32'h000029B1, 1'b0);
        add(2, "123456789", 32'h0,        0, 1'b1, 1'b0, 32'h000029B1, 1'b0);
        add(2, "123456789", 32'h29B1,     2, 1'b1, 1'b0, 32'h00000000, 1'b1);

        @(negedge clk);
        chk("rst_valid", 32'(a_ov), 32'd0);
        chk("rst_crc", a_crc, 32'd0);
        chk("rst_ok", 32'(a_ok), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ready", 32'(a_rdy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(a_rdy), 32'd1);

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        send_frame(0, pack("123456789", 32'h0, 0), 9, 1'b0);
        drive(0, 1'b1, pack("1234", 32'h0, 0) >> 0, 4, 1'b0);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 32'(a_ov), 32'd1);
            chk("bp_crc", a_crc, 32'h0376E6E7);
            chk("bp_ok", 32'(a_ok), 32'd0);
            chk("bp_ready", 32'(a_rdy), 32'd0);
            @(negedge clk);
        end
        drive(0, 1'b0, '0, 4, 1'b0);
        a_ordy = 1'b1;
        @(negedge clk);
        a_ordy = 1'b0;
        chk("bp_release_valid", 32'(a_ov), 32'd0);
        chk("bp_release_ready", 32'(a_rdy), 32'd1);
        v.sel = 0; v.data = pack("123456789", 32'h0, 0); v.len = 9;
        v.gaps = 1'b0; v.use_model = 1'b0; v.crc = 32'h0376E6E7; v.ok = 1'b0;
        run_vec("bp_next", v);

        drive(0, 1'b1, 32'h34333231, 4, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 32'h38373635, 4, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, '0, 4, 1'b0);
        chk("mid_busy", 32'(a_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_ov), 32'd0);
        chk("mid_rst_crc", a_crc, 32'd0);
        chk("mid_rst_ok", 32'(a_ok), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_ready", 32'(a_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_idle_valid", 32'(a_ov), 32'd0);
            chk("mid_idle_busy", 32'(a_busy), 32'd0);
        end
        run_vec("mid_resend", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
